// File: rtl/serial_disp_ctrl.sv
// Serial seven-segment / LED shift-chain sequencer with a valid/ready frame interface.
// Define DISP_LED_CHAIN_EN to include the LED chain phases; otherwise the led_* pins stay idle.
module serial_disp_ctrl #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [31:0] hex_data,
  input  logic [7:0]  dp_data,
  input  logic [15:0] led_data,
  output logic        busy,
  output logic        done,
  output logic        seg_clk,
  output logic        seg_do,
  output logic        seg_pen,
  output logic        seg_clr_n,
  output logic        led_clk,
  output logic        led_do,
  output logic        led_pen,
  output logic        led_clr_n
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE, LOAD, SHIFT_SEG, LATCH_SEG, SHIFT_LED, LATCH_LED
  } state_e;

  state_e           state_q;
  logic             upd_ready_q, busy_q, done_q, clr_n_q;
  logic             seg_clk_q, seg_do_q, seg_pen_q;
  logic             led_clk_q, led_do_q, led_pen_q;
  logic [DIV_W-1:0] div_q;
  logic             half_q;
  logic [5:0]       bit_q;
  logic [31:0]      hex_q;
  logic [7:0]       dp_q;
  logic [15:0]      led_q;
  logic [62:0]      seg_sr_q;
  logic [14:0]      led_sr_q;
  logic [63:0]      seg_frame_d;
  logic             div_last_d;

  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'h0: seg_decode = 8'hC0;  4'h1: seg_decode = 8'hF9;
      4'h2: seg_decode = 8'hA4;  4'h3: seg_decode = 8'hB0;
      4'h4: seg_decode = 8'h99;  4'h5: seg_decode = 8'h92;
      4'h6: seg_decode = 8'h82;  4'h7: seg_decode = 8'hF8;
      4'h8: seg_decode = 8'h80;  4'h9: seg_decode = 8'h90;
      4'hA: seg_decode = 8'h88;  4'hB: seg_decode = 8'h83;
      4'hC: seg_decode = 8'hC6;  4'hD: seg_decode = 8'hA1;
      4'hE: seg_decode = 8'h86;  default: seg_decode = 8'h8E;
    endcase
  endfunction

  always_comb begin
    seg_frame_d = '0;
    for (int unsigned i = 0; i < 8; i++)
      seg_frame_d[i*8 +: 8] = seg_decode(hex_q[i*4 +: 4]) & {~dp_q[i], 7'h7F};
  end

  assign div_last_d = (div_q == DIV_W'(CLK_DIV - 1));

  // The MSB of each chain lives in *_do_q, so the shift registers hold only the remaining bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      upd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      clr_n_q     <= 1'b0;
      seg_clk_q   <= 1'b0;
      seg_do_q    <= 1'b1;
      seg_pen_q   <= 1'b0;
      led_clk_q   <= 1'b0;
      led_do_q    <= 1'b1;
      led_pen_q   <= 1'b0;
      div_q       <= '0;
      half_q      <= 1'b0;
      bit_q       <= '0;
      hex_q       <= '0;
      dp_q        <= '0;
      led_q       <= '0;
      seg_sr_q    <= '0;
      led_sr_q    <= '0;
    end else begin
      clr_n_q <= 1'b1;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          upd_ready_q <= 1'b1;
          if (upd_valid && upd_ready_q) begin
            hex_q       <= hex_data;
            dp_q        <= dp_data;
            led_q       <= led_data;
            upd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= LOAD;
          end
        end
        LOAD: begin
          seg_do_q <= seg_frame_d[63];
          seg_sr_q <= seg_frame_d[62:0];
          led_sr_q <= ~led_q[14:0];
          div_q    <= '0;
          half_q   <= 1'b0;
          bit_q    <= '0;
          state_q  <= SHIFT_SEG;
        end
        SHIFT_SEG: begin
          if (!div_last_d) begin
            div_q <= div_q + 1'b1;
          end else begin
            div_q <= '0;
            if (!half_q) begin
              half_q    <= 1'b1;
              seg_clk_q <= 1'b1;
            end else begin
              half_q    <= 1'b0;
              seg_clk_q <= 1'b0;
              if (bit_q == 6'd63) begin
                seg_do_q  <= 1'b1;
                seg_pen_q <= 1'b1;
                state_q   <= LATCH_SEG;
              end else begin
                bit_q    <= bit_q + 6'd1;
                seg_do_q <= seg_sr_q[62];
                seg_sr_q <= {seg_sr_q[61:0], 1'b0};
              end
            end
          end
        end
        LATCH_SEG: begin
          if (!div_last_d) begin
            div_q <= div_q + 1'b1;
          end else begin
            div_q <= '0;
            if (!half_q) begin
              half_q <= 1'b1;
            end else begin
              half_q    <= 1'b0;
              seg_pen_q <= 1'b0;
`ifdef DISP_LED_CHAIN_EN
              bit_q     <= '0;
              led_do_q  <= ~led_q[15];
              state_q   <= SHIFT_LED;
`else
              upd_ready_q <= 1'b1;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= IDLE;
`endif
            end
          end
        end
        SHIFT_LED: begin
          if (!div_last_d) begin
            div_q <= div_q + 1'b1;
          end else begin
            div_q <= '0;
            if (!half_q) begin
              half_q    <= 1'b1;
              led_clk_q <= 1'b1;
            end else begin
              half_q    <= 1'b0;
              led_clk_q <= 1'b0;
              if (bit_q == 6'd15) begin
                led_do_q  <= 1'b1;
                led_pen_q <= 1'b1;
                state_q   <= LATCH_LED;
              end else begin
                bit_q    <= bit_q + 6'd1;
                led_do_q <= led_sr_q[14];
                led_sr_q <= {led_sr_q[13:0], 1'b0};
              end
            end
          end
        end
        LATCH_LED: begin
          if (!div_last_d) begin
            div_q <= div_q + 1'b1;
          end else begin
            div_q <= '0;
            if (!half_q) begin
              half_q <= 1'b1;
            end else begin
              half_q      <= 1'b0;
              led_pen_q   <= 1'b0;
              upd_ready_q <= 1'b1;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign upd_ready = upd_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign seg_clk   = seg_clk_q;
  assign seg_do    = seg_do_q;
  assign seg_pen   = seg_pen_q;
  assign seg_clr_n = clr_n_q;
  assign led_clk   = led_clk_q;
  assign led_do    = led_do_q;
  assign led_pen   = led_pen_q;
  assign led_clr_n = clr_n_q;

endmodule

// File: tb/tb_serial_disp_ctrl.sv
// Scoreboard bench for serial_disp_ctrl: stimulus pushes expected latched frames,
// a monitor reassembles the serial streams at each latch pulse and compares.
module tb_serial_disp_ctrl;

  localparam int D = 2;
`ifdef DISP_LED_CHAIN_EN
  localparam int LAT = 1 + 128*D + 2*D + 32*D + 2*D;
`else
  localparam int LAT = 1 + 128*D + 2*D;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        upd_valid = 1'b0;
  logic [31:0] hex_data = '0;
  logic [7:0]  dp_data = '0;
  logic [15:0] led_data = '0;
  logic upd_ready, busy, done;
  logic seg_clk, seg_do, seg_pen, seg_clr_n;
  logic led_clk, led_do, led_pen, led_clr_n;

  serial_disp_ctrl #(.CLK_DIV(D)) dut (
    .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .hex_data(hex_data), .dp_data(dp_data), .led_data(led_data),
    .busy(busy), .done(done),
    .seg_clk(seg_clk), .seg_do(seg_do), .seg_pen(seg_pen), .seg_clr_n(seg_clr_n),
    .led_clk(led_clk), .led_do(led_do), .led_pen(led_pen), .led_clr_n(led_clr_n)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_seg_q[$];
  logic [15:0] exp_led_q[$];

  logic [63:0] seg_word;
  logic [15:0] led_word;
  int seg_cnt, led_cnt, seg_plen, led_plen, led_act;
  logic seg_pclk, led_pclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    seg_word = '0; led_word = '0; seg_cnt = 0; led_cnt = 0;
    seg_plen = 0; led_plen = 0; led_act = 0; seg_pclk = 1'b0; led_pclk = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seg_word = '0; led_word = '0; seg_cnt = 0; led_cnt = 0;
        seg_plen = 0; led_plen = 0; seg_pclk = 1'b0; led_pclk = 1'b0;
      end else begin
        if (seg_clk && !seg_pclk) begin
          seg_word = {seg_word[62:0], seg_do};
          seg_cnt++;
        end
        seg_pclk = seg_clk;
        if (seg_pen) seg_plen++;
        else if (seg_plen != 0) begin
          if (exp_seg_q.size() == 0) chk("seg_unexpected_latch", seg_plen, 0);
          else begin
            chk("seg_frame", seg_word, exp_seg_q.pop_front());
            chk("seg_bits", seg_cnt, 64);
            chk("seg_pen_len", seg_plen, 2*D);
          end
          seg_plen = 0; seg_cnt = 0; seg_word = '0;
        end
        if (led_clk && !led_pclk) begin
          led_word = {led_word[14:0], led_do};
          led_cnt++;
        end
        led_pclk = led_clk;
        if (led_pen) led_plen++;
        else if (led_plen != 0) begin
          if (exp_led_q.size() == 0) chk("led_unexpected_latch", led_plen, 0);
          else begin
            chk("led_frame", led_word, exp_led_q.pop_front());
            chk("led_bits", led_cnt, 16);
            chk("led_pen_len", led_plen, 2*D);
          end
          led_plen = 0; led_cnt = 0; led_word = '0;
        end
        if (led_clk || led_pen || !led_do) led_act++;
      end
    end
  endtask

  task automatic accept(input logic [31:0] h, input logic [7:0] dp, input logic [15:0] l);
    int n;
    n = 0;
    @(negedge clk);
    while (!upd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("ready_timeout", n, 0);
    hex_data = h; dp_data = dp; led_data = l; upd_valid = 1'b1;
    @(posedge clk); #1;
    chk("accept_busy", busy, 1);
    chk("accept_ready_low", upd_ready, 0);
    @(negedge clk);
    upd_valid = 1'b0;
    hex_data = ~h; dp_data = ~dp; led_data = ~l;
  endtask

  task automatic wait_done(input logic expect_drop);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!upd_ready && n < 3000);
    chk("latency", n, LAT);
    chk("done_pulse", done, 1);
    chk("busy_idle", busy, 0);
    if (expect_drop) begin
      @(posedge clk); #1;
      chk("done_one_cycle", done, 0);
    end
  endtask

  task automatic send(input logic [31:0] h, input logic [7:0] dp, input logic [15:0] l,
                      input logic [63:0] es, input logic [15:0] el);
    exp_seg_q.push_back(es);
`ifdef DISP_LED_CHAIN_EN
    exp_led_q.push_back(el);
`else
    if (el != 16'h0) led_act = led_act + 0;
`endif
    accept(h, dp, l);
    wait_done(1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, upd_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_seg_pins"}, {seg_clk, seg_pen, seg_do, seg_clr_n}, 4'b0010);
    chk({tag, "_led_pins"}, {led_clk, led_pen, led_do, led_clr_n}, 4'b0010);
  endtask

  task automatic stimulus();
    int act;
    #1 rst = 1'b1;
    #1 check_reset_outputs("reset");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("release_ready", upd_ready, 1);
    chk("release_clr_n", {seg_clr_n, led_clr_n}, 2'b11);
    chk("release_clks", {seg_clk, led_clk}, 2'b00);
    act = 0;
    repeat (1000) begin
      @(posedge clk); #1;
      if (seg_pen || led_pen || seg_clk || led_clk || !upd_ready) act++;
    end
    chk("idle_quiet", act, 0);

    send(32'h0123ABCF, 8'h01, 16'h8001, 64'hC0F9A4B0_8883C60E, 16'h7FFE);
    send(32'h89ABCDEF, 8'h80, 16'h1234, 64'h00908883_C6A1868E, 16'hEDCB);
    send(32'hFFFFFFFF, 8'hFF, 16'hFFFF, 64'h0E0E0E0E_0E0E0E0E, 16'h0000);

    // back-to-back: second frame accepted on the done cycle
    exp_seg_q.push_back(64'h999282F8_C0C0C0C0);
    exp_seg_q.push_back(64'hC0F9A4B0_8883C60E);
`ifdef DISP_LED_CHAIN_EN
    exp_led_q.push_back(16'hFF0F);
    exp_led_q.push_back(16'h7FFE);
`endif
    @(negedge clk);
    hex_data = 32'h45670000; dp_data = 8'h00; led_data = 16'h00F0; upd_valid = 1'b1;
    @(posedge clk); #1;
    chk("b2b_accept_a", busy, 1);
    @(negedge clk);
    hex_data = 32'h0123ABCF; dp_data = 8'h01; led_data = 16'h8001;
    wait_done(1'b0);
    @(posedge clk); #1;
    chk("b2b_accept_b", {busy, upd_ready}, 2'b10);
    @(negedge clk); upd_valid = 1'b0;
    wait_done(1'b1);

    // reset mid-shift at segment bit 30
    accept(32'h01234567, 8'h00, 16'h5555);
    repeat (1 + 30*2*D + D - 1) @(posedge clk);
    #1 chk("mid_busy", busy, 1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("abort");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_ready", upd_ready, 1);
    send(32'h89ABCDEF, 8'h80, 16'h1234, 64'h00908883_C6A1868E, 16'hEDCB);

    repeat (10) @(posedge clk);
    chk("seg_queue_empty", exp_seg_q.size(), 0);
    chk("led_queue_empty", exp_led_q.size(), 0);
`ifndef DISP_LED_CHAIN_EN
    chk("led_idle", led_act, 0);
`endif
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join_any
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_disp_ctrl.md
# serial_disp_ctrl

Sequencing controller for the board's serial seven-segment display and LED shift-register chains. It accepts a 32-bit hex word, 8 decimal-point flags and a 16-bit LED word through a valid/ready handshake. It decodes the hex nibbles to active-low segment patterns and shifts the frames out MSB-first on a divided serial clock, then pulses the latch strobes. It sits inside the device I/O block, between the memory-mapped display registers and the seg_*/led_* board pins.

## Interface
- CLK_DIV, 2, system cycles per serial-clock half-period; legal range 1..255.
- clk  input  1  system clock; the only clock in the block.
- rst  input  1  reset, asynchronous, active-high.
- upd_valid  input  1  requester has a new frame.
- upd_ready  output  1  block can accept a frame; high only in IDLE.
- hex_data  input  32  8 hex digits; [31:28] is the leftmost digit.
- dp_data  input  8  decimal points, 1 = lit; bit 7 is the leftmost digit.
- led_data  input  16  LED states, 1 = lit.
- busy  output  1  a frame transfer is in progress.
- done  output  1  one-cycle pulse when a transfer completes.
- seg_clk, seg_do, seg_pen, seg_clr_n  output  1 each  segment chain pins.
- led_clk, led_do, led_pen, led_clr_n  output  1 each  LED chain pins.

## Operation
- States: IDLE, LOAD, SHIFT_SEG, LATCH_SEG, SHIFT_LED, LATCH_LED, then back to IDLE.
- IDLE: upd_ready = 1. A frame is accepted when upd_valid and upd_ready are both high at a rising clk edge; the inputs are captured on that edge. Input changes outside an accept edge are ignored.
- LOAD (1 cycle) builds a 64-bit segment shift register and a 16-bit LED shift register.
  - Each digit becomes the byte {dp,g,f,e,d,c,b,a}, active-low (0 = segment lit). Digit 7 occupies the top byte.
  - Decode examples, dp off: 0→0xC0, 8→0x80, F→0x8E. A lit dp clears bit 7 of its byte.
  - The LED register holds ~led_data (the chain is active-low).
- SHIFT_x, per bit, MSB first:
  - *_do is updated and *_clk driven 0 for CLK_DIV cycles.
  - *_clk is then driven 1 for CLK_DIV cycles.
  - Data is stable across the rising edge of *_clk.
  - The segment chain takes 64 bits; the LED chain takes 16 bits.
- LATCH_x: *_clk = 0 and *_pen = 1 for 2·CLK_DIV cycles; *_pen then returns to 0.
- After LATCH_LED the block returns to IDLE. done pulses for 1 cycle in the first IDLE cycle.
- Each chain's pins are only active during its own phase. In every other state: *_clk = 0, *_pen = 0, *_do = 1.
- busy = 1 in every state except IDLE.

## Timing
- Reset values, applied immediately on rst high:
  - state = IDLE; upd_ready = 0 while rst is high.
  - busy = 0, done = 0.
  - *_clk = 0, *_pen = 0, *_do = 1, *_clr_n = 0.
- After rst falls: *_clr_n = 1 and upd_ready = 1 from the first rising clk edge onward.
- Reset during a transfer aborts it with no latch pulse; the partial frame is discarded.
- With D = CLK_DIV, counting from the accept edge to the edge where upd_ready rises again:
  - LED chain compiled in: 1 + 128D + 2D + 32D + 2D cycles (D=2 → 329).
  - LED chain compiled out: 1 + 128D + 2D cycles (D=2 → 261).
- Back-to-back: if upd_valid is high during the done cycle, the next frame is accepted on that edge, so done and accept coincide.
- The bit counter and divider counter use exact widths, with no wrap beyond 64 bits or CLK_DIV. A CLK_DIV of 1 gives a serial clock of clk/2.

## Configuration
- DISP_LED_CHAIN_EN defined: the LED phases (SHIFT_LED, LATCH_LED) are included, and led_* behave as described above.
- DISP_LED_CHAIN_EN undefined:
  - LATCH_SEG goes directly to IDLE.
  - led_data is ignored.
  - led_clk = 0, led_pen = 0, led_do = 1, and led_clr_n follows the seg_clr_n rule.

## Test plan
- Reset release, idle: upd_ready is 1 on the first edge after release, both *_clr_n = 1, all clocks 0, and no pen activity for 1000 cycles.
- Accept hex_data=0x0123ABCF, dp_data=0x01, CLK_DIV=2:
  - Sampling seg_do on each seg_clk rising edge yields 64 bits beginning C0 F9 A4 B0 88 83 C6 0E.
  - seg_pen is then high for 4 cycles.
- led_data=0x8001 with LED chain enabled: the led_do bitstream is 0x7FFE over 16 rising edges, followed by a 4-cycle led_pen pulse. upd_ready returns exactly 329 cycles after the accept edge.
- Back-to-back: upd_valid held high with two different frames queued. The second frame is accepted on the done cycle and both latched values are correct.
- Reset asserted mid-SHIFT_SEG (bit 30): all outputs take their reset values immediately, no pen pulse occurs, and the next frame shifts all 64 bits correctly.
- DISP_LED_CHAIN_EN undefined: the led_* pins stay idle and upd_ready returns 261 cycles after accept.
